// File: rtl/ws2812_scroll_fader.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_scroll_fader
// Purpose  : Scrolling gradient generator for a WS2812 strip. A small store
//            of random "milestone" colours is interpolated across the strip.
//            The pattern advances one LED per frame and a new random colour
//            fades in at the source end. One 8-bit channel value is supplied
//            per accepted serialiser request.
// Ports    : clk          - clock
//            rst          - synchronous active-high reset
//            random       - random source, channel c in bits [8c+7:8c]
//            data_request - serialiser consumed color_now this cycle
//            dir          - scroll direction (sampled at frame end)
//            freeze       - hold pattern at frame end (sampled at frame end)
//            trigger      - high while holdoff is zero (frame may be sent)
//            color_now    - current channel byte, combinational from state
//            frame_done   - one-cycle pulse after the last byte of a frame
// Config   : define WS2812_SCROLL_FADER_GAMMA_EN to apply (v*v)>>8 gamma.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_scroll_fader #(
  parameter int LEDS        = 32,
  parameter int CHANNELS    = 3,
  parameter int INTERP_LOG2 = 3,
  parameter int HOLDOFF_MAX = 1200000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*CHANNELS-1:0] random,
  input  logic                  data_request,
  input  logic                  dir,
  input  logic                  freeze,
  output logic                  trigger,
  output logic [7:0]            color_now,
  output logic                  frame_done
);

  localparam int N     = 1 << INTERP_LOG2;
  localparam int MS    = ((LEDS + N - 2) >> INTERP_LOG2) + 2;
  localparam int LED_W = $clog2(LEDS);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int K_W   = $clog2(MS);
  // Largest s = (LEDS-1) + (N-1), so s needs clog2(LEDS+N-1) bits.
  localparam int S_W   = $clog2(LEDS + N - 1);
  localparam int HO_W  = (HOLDOFF_MAX > 0) ? $clog2(HOLDOFF_MAX + 1) : 1;
  localparam int M_W   = 8 * CHANNELS;
  localparam int P_W   = INTERP_LOG2 + 9;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [LED_W-1:0]       led_q;
  logic [CH_W-1:0]        ch_q;
  logic [HO_W-1:0]        ho_q;
  logic [INTERP_LOG2-1:0] ph_q;
  logic                   dir_q;
  logic                   frame_done_q;
  logic [M_W-1:0]         m_q [MS];

  // --------------------------------------------------------------------------
  // Request acceptance and frame-end detection
  // --------------------------------------------------------------------------
  logic accept_d;
  logic last_ch_d;
  logic last_led_d;
  logic frame_end_d;

  assign accept_d    = data_request && (ho_q == '0);
  assign last_ch_d   = (ch_q == CH_W'(CHANNELS - 1));
  assign last_led_d  = (led_q == LED_W'(LEDS - 1));
  assign frame_end_d = accept_d && last_ch_d && last_led_d;

  // --------------------------------------------------------------------------
  // Interpolation datapath
  // --------------------------------------------------------------------------
  logic [S_W-1:0]         pos_d;
  logic [S_W-1:0]         sum_d;
  logic [K_W-1:0]         k_d;
  logic [K_W-1:0]         k1_d;
  logic [INTERP_LOG2-1:0] f_d;
  logic [INTERP_LOG2:0]   wt_hi_d;
  logic [INTERP_LOG2:0]   wt_lo_d;
  logic [M_W-1:0]         m_lo_d;
  logic [M_W-1:0]         m_hi_d;
  logic [7:0]             a_d;
  logic [7:0]             b_d;
  logic [P_W-1:0]         mix_d;
  logic [7:0]             v_d;

  // Physical slot is mirrored when scrolling toward lower LED index.
  assign pos_d   = dir_q ? (S_W'(LEDS - 1) - S_W'(led_q)) : S_W'(led_q);
  assign sum_d   = pos_d + S_W'(ph_q);
  assign k_d     = K_W'(sum_d >> INTERP_LOG2);
  assign k1_d    = k_d + K_W'(1);
  assign f_d     = sum_d[INTERP_LOG2-1:0];
  assign wt_hi_d = {1'b0, f_d};
  assign wt_lo_d = (INTERP_LOG2 + 1)'(N) - wt_hi_d;
  assign m_lo_d  = m_q[k_d];
  assign m_hi_d  = m_q[k1_d];

  // Channel byte select with constant slices only.
  always_comb begin
    a_d = '0;
    b_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_q == CH_W'(c)) begin
        a_d = m_lo_d[8*c +: 8];
        b_d = m_hi_d[8*c +: 8];
      end
    end
  end

  // Weighted sum is held at full width (max 255*N) before the shift so the
  // fractional bits are discarded only once.
  assign mix_d = (P_W'(a_d) * P_W'(wt_lo_d)) + (P_W'(b_d) * P_W'(wt_hi_d));
  assign v_d   = 8'(mix_d >> INTERP_LOG2);

`ifdef WS2812_SCROLL_FADER_GAMMA_EN
  // Approximate square-law gamma: (v*v)>>8.
  assign color_now = 8'((16'(v_d) * 16'(v_d)) >> 8);
`else
  assign color_now = v_d;
`endif

  assign trigger    = (ho_q == '0);
  assign frame_done = frame_done_q;

  // --------------------------------------------------------------------------
  // Sequential update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q        <= '0;
      ch_q         <= '0;
      ho_q         <= '0;
      ph_q         <= '0;
      dir_q        <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < MS; i++) begin
        m_q[i] <= '0;
      end
    end else begin
      frame_done_q <= frame_end_d;
      if (frame_end_d) begin
        led_q <= '0;
        ch_q  <= '0;
        ho_q  <= HO_W'(HOLDOFF_MAX);
        dir_q <= dir;
        if (!freeze) begin
          if (ph_q != '0) begin
            ph_q <= ph_q - 1'b1;
          end else begin
            // Phase wrapped: shift milestones one slot away from the source
            // end and insert a fresh random colour there.
            ph_q <= '1;
            for (int i = MS - 1; i > 0; i--) begin
              m_q[i] <= m_q[i-1];
            end
            m_q[0] <= random;
          end
        end
      end else begin
        if (accept_d) begin
          if (!last_ch_d) begin
            ch_q <= ch_q + 1'b1;
          end else begin
            ch_q  <= '0;
            led_q <= led_q + 1'b1;
          end
        end
        if (ho_q != '0) begin
          ho_q <= ho_q - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_scroll_fader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_scroll_fader
// Purpose  : Self-checking bench for ws2812_scroll_fader (LEDS=4, CHANNELS=3,
//            INTERP_LOG2=1, HOLDOFF_MAX=3). A table of frames gives the
//            inputs applied during each frame and the expected 12 bytes;
//            expected bytes go through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_scroll_fader;

  localparam int LEDS        = 4;
  localparam int CHANNELS    = 3;
  localparam int INTERP_LOG2 = 1;
  localparam int HOLDOFF_MAX = 3;
  localparam int BYTES       = LEDS * CHANNELS;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] rnd_in;
  logic        data_request;
  logic        dir;
  logic        freeze;
  logic        trigger;
  logic [7:0]  color_now;
  logic        frame_done;

  always #5 clk = ~clk;

  ws2812_scroll_fader #(
    .LEDS       (LEDS),
    .CHANNELS   (CHANNELS),
    .INTERP_LOG2(INTERP_LOG2),
    .HOLDOFF_MAX(HOLDOFF_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .random      (rnd_in),
    .data_request(data_request),
    .dir         (dir),
    .freeze      (freeze),
    .trigger     (trigger),
    .color_now   (color_now),
    .frame_done  (frame_done)
  );

  // One frame: inputs present during the frame, and the 12 expected bytes
  // (LED0 ch0 in the most significant byte) before any gamma.
  typedef struct packed {
    logic        dir_end;     // dir at the final request
    logic        freeze_end;  // freeze at the final request
    logic        toggle_mid;  // drive inverted dir mid-frame
    logic [23:0] rnd;
    logic [95:0] exp;
  } frame_t;

  frame_t     tbl [7];
  logic [7:0] sb_q [$];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic logic [7:0] gam(input logic [7:0] v);
`ifdef WS2812_SCROLL_FADER_GAMMA_EN
    logic [15:0] sq;
    sq = 16'(v) * 16'(v);
    return sq[15:8];
`else
    return v;
`endif
  endfunction

  task automatic run_frame(input frame_t fr, input int idx);
    logic [7:0] e;
    for (int i = 0; i < BYTES; i++) begin
      @(negedge clk);
      data_request = 1'b1;
      rnd_in       = fr.rnd;
      dir          = (fr.toggle_mid && i >= 3 && i <= 7) ? ~fr.dir_end : fr.dir_end;
      // freeze is the opposite of its final value until the last byte
      freeze       = (i == BYTES - 1) ? fr.freeze_end : ~fr.freeze_end;
      sb_q.push_back(gam(fr.exp[95-8*i -: 8]));
      if (i == 0) check($sformatf("f%0d trigger_start", idx), 32'(trigger), 32'd1);
      if (sb_q.size() == 0) begin
        check($sformatf("f%0d sb_empty", idx), 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("f%0d byte%0d", idx, i), 32'(color_now), 32'(e));
      end
    end
    // Holdoff window: requests here must be ignored.
    for (int c = 1; c <= HOLDOFF_MAX + 1; c++) begin
      @(negedge clk);
      data_request = (c <= HOLDOFF_MAX) ? 1'b1 : 1'b0;
      check($sformatf("f%0d frame_done c%0d", idx, c), 32'(frame_done), (c == 1) ? 32'd1 : 32'd0);
      check($sformatf("f%0d trigger c%0d", idx, c), 32'(trigger),
            (c == HOLDOFF_MAX + 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    //            dir  frz  tog  rnd        expected bytes
    tbl[0] = '{1'b0, 1'b0, 1'b0, 24'h204080, 96'h000000_000000_000000_000000};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 24'h204080, 96'h402010_000000_000000_000000};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 24'hFFFFFF, 96'h804020_402010_000000_000000};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 24'h102030, 96'h804020_402010_000000_000000};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 24'hAAAAAA, 96'h000000_402010_804020_583018};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 24'h555555, 96'h402010_804020_583018_302010};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 24'h204080, 96'h000000_000000_000000_000000};

    rst          = 1'b1;
    data_request = 1'b0;
    dir          = 1'b0;
    freeze       = 1'b0;
    rnd_in       = 24'h204080;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset trigger", 32'(trigger), 32'd1);
    check("reset color_now", 32'(color_now), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);

    for (int f = 0; f < 6; f++) run_frame(tbl[f], f);

    // Mid-frame reset after 5 accepted bytes.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data_request = 1'b1;
    end
    @(negedge clk);
    data_request = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst trigger", 32'(trigger), 32'd1);
    check("midrst frame_done", 32'(frame_done), 32'd0);
    check("midrst color_now", 32'(color_now), 32'd0);

    // Fresh frame from reset state: all zero, frame_done after exactly 12.
    run_frame(tbl[6], 6);

    check("sb drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ws2812_scroll_fader.md
# ws2812_scroll_fader

Parametrised successor of the WS2812 random-milestone fader. Generates a scrolling gradient between random milestone colours for an LED strip with a configurable channel count (RGB/RGBW) and interpolation depth. Adds runtime scroll direction, freeze, and a frame-done pulse. Sits between the random source and the WS2812 serialiser, supplying one 8-bit channel value per `data_request`.

## Interface

- `LEDS`, 32: LEDs on the strip, ≥2.
- `CHANNELS`, 3: bytes per LED; 3 for RGB, 4 for RGBW.
- `INTERP_LOG2`, 3: log2 of interpolation steps N between milestones; N = 2^INTERP_LOG2, ≥1.
- `HOLDOFF_MAX`, 1200000: idle cycles after each full frame.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `random`  in  8*CHANNELS  random source; channel c uses bits [8c+7:8c].
- `data_request`  in  1  serialiser consumed `color_now` this cycle.
- `dir`  in  1  0: pattern scrolls toward higher LED index; 1: toward lower.
- `freeze`  in  1  1: no scroll step at frame end.
- `trigger`  out  1  high when holdoff is 0, meaning a frame may be transmitted.
- `color_now`  out  8  current channel value, combinational from state.
- `frame_done`  out  1  one-cycle pulse after the last byte of a frame.

## Operation

- **State**
  - Milestone store M[0..MS-1] of CHANNELS×8 bits, where MS = ((LEDS+N-2)>>INTERP_LOG2)+2.
  - Phase `ph` in [0, N-1].
  - LED counter `led`, channel counter `ch`, holdoff counter.
  - Latched direction `dir_q`.
- **Per byte**
  - p = dir_q ? LEDS-1-led : led.
  - s = p+ph; k = s>>INTERP_LOG2; f = s & (N-1).
  - color_now = (M[k][ch]·(N−f) + M[k+1][ch]·f) >> INTERP_LOG2.
  - Intermediate width is 9+INTERP_LOG2 bits; no truncation before the shift.
- **Accepted request:** `data_request` with holdoff==0. Requests while holdoff≠0 are ignored.
- **Counter advance on an accepted request**
  - ch<CHANNELS-1: ch++.
  - Otherwise ch=0 and, if led<LEDS-1, led++.
  - Otherwise the request ends the frame.
- **Frame end** (same edge as the ending request)
  - led=0, ch=0, holdoff=HOLDOFF_MAX.
  - `frame_done`=1 for the next cycle.
  - `dir_q`←`dir`.
  - If `freeze`=1: ph and M are unchanged.
  - Else if ph≠0: ph−1.
  - Else: ph=N-1, M[i]←M[i−1] for i≥1, and M[0]←{random}.
  - Net effect: the pattern advances one LED per frame; each new colour fades in at the source end.
- **`dir` / `freeze`:** sampled only at frame end. `dir_q` applies from the next frame. Mid-frame changes have no effect.
- **Holdoff:** decrements by 1 per cycle while nonzero.
- **Reset:** has priority over all other updates. Mid-frame reset aborts the frame.
- **Reset values:** all state 0. Outputs `trigger`=1, `color_now`=0, `frame_done`=0.

## Timing

- `color_now` is valid in the same cycle as the state it is computed from. After an accepted request, the next byte is valid one cycle later.
- Last request at edge T:
  - `trigger` is low for cycles T+1 … T+HOLDOFF_MAX.
  - `trigger` is high again at T+HOLDOFF_MAX+1.
  - `frame_done` is high for cycle T+1 only.
- Back-to-back requests on consecutive cycles are supported.
- Frame byte order: LED 0..LEDS-1 by transmission slot; within each LED, channel 0 first.

## Configuration

- Macro: `WS2812_SCROLL_FADER_GAMMA_EN`.
- **Defined:** `color_now` = (v·v)>>8 applied to the interpolated value v, as an approximate square-law gamma. Purely combinational; no added latency.
- **Undefined:** `color_now` = v.

## Test plan

All scenarios use LEDS=4, CHANNELS=3, INTERP_LOG2=1, HOLDOFF_MAX=3, and random=0x204080 (ch0=0x80, ch1=0x40, ch2=0x20), unless stated otherwise.

- **Reset then frame 1:** 12 requests → all `color_now`=0x00; `frame_done` pulses once; `trigger` low exactly 3 cycles, then high; ph=1, M[0]=0x80/0x40/0x20.
- **Frame 2, dir=0:** LED0 = 0x40,0x20,0x10; LEDs 1–3 = 0. **Frame 3:** LED0 = 0x80,0x40,0x20; LED1 = 0x40,0x20,0x10.
- **Direction:** set dir=1 during frame 1 → frame 2 LED3 = 0x40,0x20,0x10, LED0 = 0. Toggling dir during frame 2 does not alter frame 2 bytes.
- **Freeze:** freeze=1 at end of frame 3 → frame 4 identical to frame 3; `random` not sampled.
- **Ignored requests / mid-frame reset:** requests during holdoff → counters unchanged. rst after 5 bytes → next request yields LED0 ch0 = 0, and `trigger`=1 the cycle after rst.
- **Gamma macro defined:** frame 3 LED0 = 0x40,0x10,0x04. Macro undefined: 0x80,0x40,0x20.
